// File: rtl/wb_regfile_arbiter_pkg.sv
// Shared defines for the register-file write-port arbiter:
// FSM encoding and the hard-wired zero register address.
package wb_regfile_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DEBUG = 2'd2
    } arb_state_t;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/wb_regfile_arbiter.sv
// Register-file write-port owner: shares the port between write-back
// and the debug unit, and sequences halt -> drain -> debug -> resume.
module wb_regfile_arbiter
    import wb_regfile_arbiter_pkg::*;
#(
    parameter int NB_DATA      = 32,
    parameter int NB_ADDR      = 5,
    parameter int DRAIN_CYCLES = 4,
    parameter int NB_CNT       = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_wb_regWrite,
    input  logic [NB_ADDR-1:0] i_wb_reg2write,
    input  logic [NB_DATA-1:0] i_wb_write_data,
    input  logic               i_dbg_halt_req,
    input  logic               i_dbg_valid,
    input  logic [NB_ADDR-1:0] i_dbg_addr,
    input  logic [NB_DATA-1:0] i_dbg_data,
    output logic               o_dbg_ready,
    output logic               o_halt,
    output logic               o_dbg_granted,
    output logic               o_rf_we,
    output logic [NB_ADDR-1:0] o_rf_addr,
    output logic [NB_DATA-1:0] o_rf_data,
    output logic               o_err,
    output logic [NB_CNT-1:0]  o_dbg_wr_count
);

    localparam int NB_DC = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    arb_state_t        r_state;
    logic [NB_DC-1:0]  r_cnt;
    logic              r_halt;
    logic              r_granted;
    logic              r_ready;
    logic              r_err;
    logic [NB_CNT-1:0] r_wr_count;

    logic w_we_raw;
    logic w_dbg_xfer;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_RUN;
            r_cnt     <= '0;
            r_halt    <= 1'b0;
            r_granted <= 1'b0;
            r_ready   <= 1'b0;
        end else begin
            unique case (r_state)
                ST_RUN: begin
                    if (i_dbg_halt_req) begin
                        r_state <= ST_DRAIN;
                        r_cnt   <= NB_DC'(DRAIN_CYCLES - 1);
                        r_halt  <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (!i_dbg_halt_req) begin
                        r_state <= ST_RUN;
                        r_cnt   <= '0;
                        r_halt  <= 1'b0;
                    end else if (r_cnt == '0) begin
                        r_state   <= ST_DEBUG;
                        r_granted <= 1'b1;
                        r_ready   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DEBUG: begin
                    if (!i_dbg_halt_req) begin
                        r_state   <= ST_RUN;
                        r_halt    <= 1'b0;
                        r_granted <= 1'b0;
                        r_ready   <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_RUN;
                    r_cnt     <= '0;
                    r_halt    <= 1'b0;
                    r_granted <= 1'b0;
                    r_ready   <= 1'b0;
                end
            endcase
        end
    end

    assign w_dbg_xfer = i_dbg_valid & r_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err      <= 1'b0;
            r_wr_count <= '0;
        end else begin
            if (r_granted && i_wb_regWrite) begin
                r_err <= 1'b1;
            end
            if (w_dbg_xfer) begin
                r_wr_count <= r_wr_count + 1'b1;
            end
        end
    end

    // Port mux: debug owns the port only once the pipeline is drained.
    assign w_we_raw  = r_granted ? i_dbg_valid : i_wb_regWrite;
    assign o_rf_addr = r_granted ? i_dbg_addr  : i_wb_reg2write;
    assign o_rf_data = r_granted ? i_dbg_data  : i_wb_write_data;
    assign o_rf_we   = w_we_raw & i_rst_n &
                       (o_rf_addr != NB_ADDR'(REG_ZERO));

    assign o_halt         = r_halt;
    assign o_dbg_granted  = r_granted;
    assign o_dbg_ready    = r_ready;
    assign o_err          = r_err;
    assign o_dbg_wr_count = r_wr_count;

endmodule

// File: tb/tb_wb_regfile_arbiter.sv
// Directed bench for wb_regfile_arbiter: pass-through, zero protect,
// halt/drain timing, debug writes, abort, async reset, counter wrap.
module tb_wb_regfile_arbiter;

    localparam int NB_DATA = 32;
    localparam int NB_ADDR = 5;
    localparam int NB_CNT  = 8;

    logic               i_clk;
    logic               i_rst_n;
    logic               i_wb_regWrite;
    logic [NB_ADDR-1:0] i_wb_reg2write;
    logic [NB_DATA-1:0] i_wb_write_data;
    logic               i_dbg_halt_req;
    logic               i_dbg_valid;
    logic [NB_ADDR-1:0] i_dbg_addr;
    logic [NB_DATA-1:0] i_dbg_data;
    logic               o_dbg_ready;
    logic               o_halt;
    logic               o_dbg_granted;
    logic               o_rf_we;
    logic [NB_ADDR-1:0] o_rf_addr;
    logic [NB_DATA-1:0] o_rf_data;
    logic               o_err;
    logic [NB_CNT-1:0]  o_dbg_wr_count;

    int errors = 0;
    int checks = 0;

    wb_regfile_arbiter #(
        .NB_DATA(NB_DATA),
        .NB_ADDR(NB_ADDR),
        .DRAIN_CYCLES(4),
        .NB_CNT(NB_CNT)
    ) dut (
        .i_clk(i_clk),
        .i_rst_n(i_rst_n),
        .i_wb_regWrite(i_wb_regWrite),
        .i_wb_reg2write(i_wb_reg2write),
        .i_wb_write_data(i_wb_write_data),
        .i_dbg_halt_req(i_dbg_halt_req),
        .i_dbg_valid(i_dbg_valid),
        .i_dbg_addr(i_dbg_addr),
        .i_dbg_data(i_dbg_data),
        .o_dbg_ready(o_dbg_ready),
        .o_halt(o_halt),
        .o_dbg_granted(o_dbg_granted),
        .o_rf_we(o_rf_we),
        .o_rf_addr(o_rf_addr),
        .o_rf_data(o_rf_data),
        .o_err(o_err),
        .o_dbg_wr_count(o_dbg_wr_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wb(input logic we, input logic [NB_ADDR-1:0] a,
                      input logic [NB_DATA-1:0] d);
        i_wb_regWrite   = we;
        i_wb_reg2write  = a;
        i_wb_write_data = d;
    endtask

    task automatic dbg(input logic v, input logic [NB_ADDR-1:0] a,
                       input logic [NB_DATA-1:0] d);
        i_dbg_valid = v;
        i_dbg_addr  = a;
        i_dbg_data  = d;
    endtask

    initial begin
        i_rst_n        = 1'b0;
        i_dbg_halt_req = 1'b0;
        wb(1'b1, 5'd8, 32'h1);
        dbg(1'b0, 5'd0, 32'h0);

        // Reset state
        #2;
        chk("rst_we", o_rf_we, 0);
        chk("rst_halt", o_halt, 0);
        chk("rst_grant", o_dbg_granted, 0);
        chk("rst_ready", o_dbg_ready, 0);
        chk("rst_err", o_err, 0);
        chk("rst_cnt", o_dbg_wr_count, 0);
        tick();
        tick();
        i_rst_n = 1'b1;

        // RUN pass-through
        wb(1'b1, 5'd8, 32'hDEADBEEF);
        #1;
        chk("run_we", o_rf_we, 1);
        chk("run_addr", o_rf_addr, 8);
        chk("run_data", o_rf_data, 64'hDEADBEEF);
        chk("run_halt", o_halt, 0);

        // Register 0 protection
        wb(1'b1, 5'd0, 32'h1234);
        #1;
        chk("zero_we", o_rf_we, 0);
        wb(1'b0, 5'd0, 32'h0);

        // Halt sequence: halt_req in cycle T
        tick();
        i_dbg_halt_req = 1'b1;
        tick();
        chk("t1_halt", o_halt, 1);
        chk("t1_grant", o_dbg_granted, 0);
        chk("t1_ready", o_dbg_ready, 0);
        tick();
        chk("t2_grant", o_dbg_granted, 0);
        tick();
        wb(1'b1, 5'd5, 32'hCAFEF00D);
        #1;
        chk("t3_we", o_rf_we, 1);
        chk("t3_addr", o_rf_addr, 5);
        chk("t3_data", o_rf_data, 64'hCAFEF00D);
        wb(1'b0, 5'd0, 32'h0);
        tick();
        chk("t4_grant", o_dbg_granted, 0);
        tick();
        chk("t5_grant", o_dbg_granted, 1);
        chk("t5_ready", o_dbg_ready, 1);
        chk("t5_halt", o_halt, 1);

        // Debug writes
        dbg(1'b1, 5'd1, 32'h11);
        #1;
        chk("d1_we", o_rf_we, 1);
        chk("d1_addr", o_rf_addr, 1);
        chk("d1_data", o_rf_data, 64'h11);
        tick();
        dbg(1'b1, 5'd2, 32'h22);
        #1;
        chk("d2_we", o_rf_we, 1);
        chk("d2_addr", o_rf_addr, 2);
        chk("d2_data", o_rf_data, 64'h22);
        tick();
        dbg(1'b1, 5'd0, 32'h33);
        #1;
        chk("d0_we", o_rf_we, 0);
        tick();
        dbg(1'b0, 5'd0, 32'h0);
        #1;
        chk("dbg_cnt3", o_dbg_wr_count, 3);

        // Pipeline write during DEBUG is dropped and flagged
        wb(1'b1, 5'd9, 32'h99);
        #1;
        chk("dbgwb_we", o_rf_we, 0);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        chk("err_set", o_err, 1);
        i_dbg_halt_req = 1'b0;
        tick();
        chk("resume_halt", o_halt, 0);
        chk("resume_grant", o_dbg_granted, 0);
        chk("err_sticky", o_err, 1);
        wb(1'b1, 5'd7, 32'h77);
        #1;
        chk("resume_we", o_rf_we, 1);
        wb(1'b0, 5'd0, 32'h0);

        // Abort during DRAIN with a held debug request
        dbg(1'b1, 5'd3, 32'hAB);
        i_dbg_halt_req = 1'b1;
        tick();
        chk("ab1_halt", o_halt, 1);
        chk("ab1_ready", o_dbg_ready, 0);
        tick();
        chk("ab2_halt", o_halt, 1);
        chk("ab2_ready", o_dbg_ready, 0);
        i_dbg_halt_req = 1'b0;
        tick();
        chk("ab_halt", o_halt, 0);
        for (int i = 0; i < 6; i++) begin
            chk("ab_grant", o_dbg_granted, 0);
            chk("ab_we", o_rf_we, 0);
            tick();
        end
        chk("ab_cnt", o_dbg_wr_count, 3);
        dbg(1'b0, 5'd0, 32'h0);

        // Async reset while in DEBUG
        i_dbg_halt_req = 1'b1;
        repeat (5) tick();
        chk("pre_rst_grant", o_dbg_granted, 1);
        dbg(1'b1, 5'd6, 32'h66);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("arst_halt", o_halt, 0);
        chk("arst_grant", o_dbg_granted, 0);
        chk("arst_ready", o_dbg_ready, 0);
        chk("arst_err", o_err, 0);
        chk("arst_cnt", o_dbg_wr_count, 0);
        chk("arst_we", o_rf_we, 0);
        dbg(1'b0, 5'd0, 32'h0);
        tick();
        i_rst_n = 1'b1;

        // Counter wrap after 256 transfers
        repeat (5) tick();
        chk("wrap_grant", o_dbg_granted, 1);
        dbg(1'b1, 5'd4, 32'h44);
        repeat (255) tick();
        chk("wrap_255", o_dbg_wr_count, 255);
        tick();
        dbg(1'b0, 5'd0, 32'h0);
        chk("wrap_0", o_dbg_wr_count, 0);
        i_dbg_halt_req = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
